// File: rtl/seq_gen_prog.sv
// Programmable sequence generator: plays entries 0..len_q of a writable table onto out,
// one entry per enabled clock, in loop or one-shot mode.
module seq_gen_prog #(
  parameter int                     WIDTH      = 3,
  parameter int                     DEPTH      = 4,
  parameter logic [WIDTH*DEPTH-1:0] INIT_TABLE = 12'hAD0,
  localparam int                    AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             mode,
  input  logic [AW-1:0]    len,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tbl_q [DEPTH];
  logic [WIDTH-1:0] tbl_d [DEPTH];
  logic [WIDTH-1:0] out_q, out_d;
  logic [AW-1:0]    idx_q, idx_d, len_q, len_d;
  logic             mode_q, mode_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  logic             addr_ok;
  logic [AW-1:0]    len_clamp;
  logic [AW-1:0]    idx_nxt;
  logic             at_last;

  // Power-of-two depth covers the whole address/len range, so no range check is needed.
  if (DEPTH == (1 << AW)) begin : g_pow2
    assign addr_ok   = 1'b1;
    assign len_clamp = len;
  end else begin : g_npow2
    assign addr_ok   = (wr_addr < AW'(DEPTH));
    assign len_clamp = (len > AW'(DEPTH - 1)) ? AW'(DEPTH - 1) : len;
  end

  assign idx_nxt = idx_q + AW'(1);
  assign at_last = (idx_q == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      len_q   <= AW'(DEPTH - 1);
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= INIT_TABLE[i*WIDTH +: WIDTH];
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tbl_q   <= tbl_d;
    end
  end

  // Reads below use tbl_q, so a same-edge write is only seen from the next edge.
  always_comb begin
    tbl_d = tbl_q;
    if (wr_en && addr_ok) tbl_d[wr_addr] = wr_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop) state_d = IDLE;
               else if (en && at_last && mode_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d   = out_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        len_d   = len_clamp;
        mode_d  = mode;
        idx_d   = '0;
        out_d   = tbl_q[0];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      RUN: begin
        if (stop) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (en) begin
          if (!at_last) begin
            idx_d = idx_nxt;
            out_d = tbl_q[idx_nxt];
          end else if (mode_q) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = '0;
            out_d = tbl_q[0];
          end
        end
      end
      default: ;
    endcase
  end

  assign out   = out_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_gen_prog.sv
// Self-checking bench for seq_gen_prog at default parameters (WIDTH=3, DEPTH=4).
module tb_seq_gen_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, stop = 1'b0, en = 1'b0, mode = 1'b0, wr_en = 1'b0;
  logic [1:0] len = '0, wr_addr = '0, idx;
  logic [2:0] wr_data = '0, out;
  logic       valid, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] o;
    logic [1:0] i;
    logic       v;
    logic       b;
    logic       d;
  } obs_t;

  obs_t exp_q[$];

  seq_gen_prog dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .mode(mode), .len(len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out(out), .valid(valid), .busy(busy), .done(done), .idx(idx)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(int o, int i, bit v, bit b, bit d);
    obs_t r;
    r.o = 3'(o); r.i = 2'(i); r.v = v; r.b = b; r.d = d;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.o = out; r.i = idx; r.v = valid; r.b = busy; r.d = done;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst = 1'b1;
    tick();
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset got %h expected %h", o, e);
    end
    rst = 1'b0;
  endtask

  task automatic test_legacy_loop();
    obs_t e, o;
    int seq [4];
    seq = '{0, 2, 3, 5};
    start = 1'b1; mode = 1'b0; len = 2'd3; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(mk(seq[i % 4], i % 4, 1, 1, 0));
      tick();
      start = 1'b0;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL legacy_loop[%0d] got %h expected %h", i, o, e);
      end
    end
    stop = 1'b1;
    exp_q.push_back(mk(2, 1, 0, 0, 0));
    tick();
    stop = 1'b0;
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL legacy_stop got %h expected %h", o, e);
    end
  endtask

  task automatic test_oneshot();
    obs_t e, o;
    int   wv [3];
    obs_t ex [5];
    wv = '{7, 1, 4};
    wr_en = 1'b1;
    for (int a = 0; a < 3; a++) begin
      wr_addr = 2'(a); wr_data = 3'(wv[a]);
      exp_q.push_back(mk(2, 1, 0, 0, 0));
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL oneshot_write_idle[%0d] got %h expected %h", a, o, e);
      end
    end
    wr_en = 1'b0;
    ex = '{mk(7, 0, 1, 1, 0), mk(1, 1, 1, 1, 0), mk(4, 2, 1, 1, 0),
           mk(4, 2, 0, 0, 1), mk(4, 2, 0, 0, 0)};
    mode = 1'b1; len = 2'd2; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start = (i == 0 || i == 4);  // second pulse lands in DONE and must be ignored
      exp_q.push_back(ex[i]);
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL oneshot[%0d] got %h expected %h", i, o, e);
      end
    end
    start = 1'b0;
    exp_q.push_back(mk(4, 2, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL oneshot_idle got %h expected %h", o, e);
    end
    mode = 1'b0;
  endtask

  task automatic test_stall_clamp();
    obs_t e, o;
    obs_t ex [8];
    bit   ens [8];
    bit   sts [8];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex  = '{mk(0, 0, 1, 1, 0), mk(2, 1, 1, 1, 0), mk(2, 1, 1, 1, 0), mk(2, 1, 1, 1, 0),
            mk(2, 1, 1, 1, 0), mk(3, 2, 1, 1, 0), mk(5, 3, 1, 1, 0), mk(0, 0, 1, 1, 0)};
    ens = '{1, 1, 0, 0, 0, 1, 1, 1};
    sts = '{1, 0, 1, 1, 1, 0, 0, 0};
    mode = 1'b0; len = 2'b11;
    for (int i = 0; i < 8; i++) begin
      en = ens[i]; start = sts[i];
      exp_q.push_back(ex[i]);
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall[%0d] got %h expected %h", i, o, e);
      end
    end
    start = 1'b0; en = 1'b1; stop = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    tick();
    stop = 1'b0;
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL stall_stop got %h expected %h", o, e);
    end
  endtask

  task automatic test_stop_reset();
    obs_t e, o;
    obs_t ex [11];
    mode = 1'b0; len = 2'd3; en = 1'b1;
    ex = '{mk(0, 0, 1, 1, 0), mk(2, 1, 1, 1, 0), mk(3, 2, 1, 1, 0), mk(3, 2, 0, 0, 0),
           mk(0, 0, 1, 1, 0), mk(2, 1, 1, 1, 0), mk(0, 0, 0, 0, 0),
           mk(0, 0, 1, 1, 0), mk(2, 1, 1, 1, 0), mk(3, 2, 1, 1, 0), mk(5, 3, 1, 1, 0)};
    for (int i = 0; i < 11; i++) begin
      start = (i == 0 || i == 4 || i == 7);
      stop  = (i == 3);
      rst   = (i == 6);
      wr_en = (i == 4); wr_addr = 2'd2; wr_data = 3'd6;
      exp_q.push_back(ex[i]);
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stop_reset[%0d] got %h expected %h", i, o, e);
      end
    end
    start = 1'b0; rst = 1'b0; wr_en = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_write_during_run();
    obs_t e, o;
    obs_t ex [10];
    mode = 1'b0; len = 2'd3; en = 1'b1;
    ex = '{mk(0, 0, 1, 1, 0), mk(2, 1, 1, 1, 0), mk(3, 2, 1, 1, 0), mk(5, 3, 1, 1, 0),
           mk(0, 0, 1, 1, 0), mk(2, 1, 1, 1, 0), mk(3, 2, 1, 1, 0), mk(5, 3, 1, 1, 0),
           mk(6, 0, 1, 1, 0), mk(6, 0, 0, 0, 0)};
    for (int i = 0; i < 10; i++) begin
      start = (i == 0);
      stop  = (i == 9);
      wr_en = (i == 4); wr_addr = 2'd0; wr_data = 3'd6;
      exp_q.push_back(ex[i]);
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL write_run[%0d] got %h expected %h", i, o, e);
      end
    end
    stop = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_len0();
    obs_t e, o;
    obs_t ex [8];
    len = 2'd0; en = 1'b1;
    ex = '{mk(6, 0, 1, 1, 0), mk(6, 0, 1, 1, 0), mk(6, 0, 1, 1, 0), mk(6, 0, 1, 1, 0),
           mk(6, 0, 0, 0, 0), mk(6, 0, 1, 1, 0), mk(6, 0, 0, 0, 1), mk(6, 0, 0, 0, 0)};
    for (int i = 0; i < 8; i++) begin
      start = (i == 0 || i == 5);
      stop  = (i == 4);
      mode  = (i >= 5);
      exp_q.push_back(ex[i]);
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL len0[%0d] got %h expected %h", i, o, e);
      end
    end
    start = 1'b0; stop = 1'b0; mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_legacy_loop();
    test_oneshot();
    test_stall_clamp();
    test_stop_reset();
    test_write_during_run();
    test_len0();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
